// File: rtl/mux_2_to_1_pkg.sv
// Shared constants for the registered 2:1 multiplexer and its optional
// selection statistics (enabled by defining MUX_2_TO_1_STATS_EN).
package mux_2_to_1_pkg;

  // Select encoding: sel=0 picks a, sel=1 picks b.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Statistics counter width and its saturation value.
  localparam int             CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Default datapath width.
  localparam int DEFAULT_WIDTH = 1;

endpackage : mux_2_to_1_pkg

// File: rtl/mux_2_to_1_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at CNT_MAX instead of wrapping.
module mux_2_to_1_sat_cnt
  import mux_2_to_1_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled events; clear wins over enable; stop at the maximum.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule : mux_2_to_1_sat_cnt

// File: rtl/mux_2_to_1.sv
// Registered 2:1 multiplexer with a valid qualifier and one-cycle latency.
// Optional per-input selection counters are built when the macro
// MUX_2_TO_1_STATS_EN is defined; otherwise those ports do not exist.
module mux_2_to_1
  import mux_2_to_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
`ifdef MUX_2_TO_1_STATS_EN
  ,
  output logic [CNT_W-1:0] sel_a_count,
  output logic [CNT_W-1:0] sel_b_count
`endif
);

  logic [WIDTH-1:0] y_next;

  // Pick the candidate output bitwise from the current inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    y_next = a;
    if (sel == SEL_B) begin
      y_next = b;
    end
  end

  // Capture the selection on each accepted input; reset overrides valid,
  // so an input arriving with rst high is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= y_next;
      end
    end
  end

`ifdef MUX_2_TO_1_STATS_EN
  logic cnt_a_en;
  logic cnt_b_en;

  // Each acceptance bumps exactly the counter matching its select.
  always_comb begin
    cnt_a_en = in_valid && (sel == SEL_A);
    cnt_b_en = in_valid && (sel == SEL_B);
  end

  mux_2_to_1_sat_cnt u_cnt_a (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_a_en),
    .count (sel_a_count)
  );

  mux_2_to_1_sat_cnt u_cnt_b (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_b_en),
    .count (sel_b_count)
  );
`endif

endmodule : mux_2_to_1

// File: tb/tb_mux_2_to_1.sv
// Directed bench for mux_2_to_1: a 1-bit and an 8-bit instance share
// clock, reset, select and valid. Statistics checks are compiled only
// when MUX_2_TO_1_STATS_EN is defined.
module tb_mux_2_to_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       in_valid;
  logic       a1, b1, y1, ov1;
  logic [7:0] a8, b8, y8;
  logic       ov8;

  int errors = 0;
  int checks = 0;

`ifdef MUX_2_TO_1_STATS_EN
  logic [15:0] ca1, cb1, ca8, cb8;
`endif

  always #5 clk = ~clk;

  mux_2_to_1 #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .a         (a1),
    .b         (b1),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y1),
    .out_valid (ov1)
`ifdef MUX_2_TO_1_STATS_EN
    ,
    .sel_a_count (ca1),
    .sel_b_count (cb1)
`endif
  );

  mux_2_to_1 #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y8),
    .out_valid (ov8)
`ifdef MUX_2_TO_1_STATS_EN
    ,
    .sel_a_count (ca8),
    .sel_b_count (cb8)
`endif
  );

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; sel = 1'b0;
    a1 = 1'b1; b1 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    step();
    step();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL reset_y1 got=%b exp=0", y1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got=%b exp=0", ov1); end
    checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL reset_y8 got=%h exp=00", y8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8 got=%b exp=0", ov8); end
`ifdef MUX_2_TO_1_STATS_EN
    checks++; if (ca8 !== 16'h0 || cb8 !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", ca8, cb8); end
`endif
  endtask

  task automatic test_select();
    rst = 1'b0; in_valid = 1'b1; sel = 1'b0;
    a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
    step();
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL sel_a_y1 got=%b exp=1", y1); end
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL sel_a_ov1 got=%b exp=1", ov1); end
    checks++; if (y8 !== 8'hA5) begin errors++; $display("FAIL sel_a_y8 got=%h exp=a5", y8); end
    sel = 1'b1;
    step();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL sel_b_y1 got=%b exp=0", y1); end
    checks++; if (y8 !== 8'h3C) begin errors++; $display("FAIL sel_b_y8 got=%h exp=3c", y8); end
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL sel_b_ov8 got=%b exp=1", ov8); end
  endtask

  // Expects y1=0 and y8=8'h3C left over from test_select.
  task automatic test_hold();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); sel = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      step();
      checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL hold_y1 cyc=%0d got=%b exp=0", i, y1); end
      checks++; if (y8 !== 8'h3C) begin errors++; $display("FAIL hold_y8 cyc=%0d got=%h exp=3c", i, y8); end
      checks++; if (ov8 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL hold_ov cyc=%0d got=%b%b exp=00", i, ov1, ov8); end
    end
  endtask

  // Full-throughput stream; inputs also wiggle mid-cycle after capture.
  task automatic test_back_to_back();
    logic [7:0] exp8;
    logic       exp1;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); sel = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      exp8 = sel ? b8 : a8;
      exp1 = sel ? b1 : a1;
      @(posedge clk);
      #1;
      a8 = ~a8; b8 = ~b8; a1 = ~a1; b1 = ~b1; sel = ~sel;
      #2;
      checks++; if (y8 !== exp8 || ov8 !== 1'b1) begin errors++; $display("FAIL b2b_y8 cyc=%0d got=%h/%b exp=%h/1", i, y8, ov8, exp8); end
      checks++; if (y1 !== exp1 || ov1 !== 1'b1) begin errors++; $display("FAIL b2b_y1 cyc=%0d got=%b/%b exp=%b/1", i, y1, ov1, exp1); end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b0; in_valid = 1'b1; sel = 1'b0; a8 = 8'h11; b8 = 8'hEE;
    step();
    checks++; if (y8 !== 8'h11) begin errors++; $display("FAIL mid_pre got=%h exp=11", y8); end
    rst = 1'b1; a8 = 8'h22;
    step();
    checks++; if (y8 !== 8'h00 || ov8 !== 1'b0) begin errors++; $display("FAIL mid_drop got=%h/%b exp=00/0", y8, ov8); end
    rst = 1'b0; a8 = 8'h33;
    step();
    checks++; if (y8 !== 8'h33 || ov8 !== 1'b1) begin errors++; $display("FAIL mid_first got=%h/%b exp=33/1", y8, ov8); end
    in_valid = 1'b0; a8 = 8'h44;
    step();
    checks++; if (y8 !== 8'h33 || ov8 !== 1'b0) begin errors++; $display("FAIL mid_pulse got=%h/%b exp=33/0", y8, ov8); end
  endtask

`ifdef MUX_2_TO_1_STATS_EN
  task automatic test_stats();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b1; sel = 1'b0;
    repeat (3) step();
    checks++; if (ca8 !== 16'd3 || cb8 !== 16'd0) begin errors++; $display("FAIL stats_a3 got=%h/%h exp=0003/0000", ca8, cb8); end
    rst = 1'b1; step(); rst = 1'b0;
    sel = 1'b1;
    repeat (70000) step();
    checks++; if (cb8 !== 16'hFFFF || cb1 !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got=%h/%h exp=ffff", cb8, cb1); end
    checks++; if (ca8 !== 16'h0) begin errors++; $display("FAIL stats_a0 got=%h exp=0000", ca8); end
    rst = 1'b1;
    step();
    checks++; if (ca8 !== 16'h0 || cb8 !== 16'h0) begin errors++; $display("FAIL stats_clr got=%h/%h exp=0/0", ca8, cb8); end
    rst = 1'b0; in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
`ifdef MUX_2_TO_1_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_2_to_1

// File: doc/mux_2_to_1.md
MUX_2_TO_1 -- requirements
Module: mux_2_to_1

Interface
REQ-001 Parameter: WIDTH, default 1, data width of a, b and y; legal range 1..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  WIDTH  data input selected when sel=0.
REQ-005 Port: b  input  WIDTH  data input selected when sel=1.
REQ-006 Port: sel  input  1  select; 0 -> a, 1 -> b.
REQ-007 Port: in_valid  input  1  qualifies a, b and sel for capture in the current cycle.
REQ-008 Port: y  output  WIDTH  registered mux result.
REQ-009 Port: out_valid  output  1  high for exactly the cycle after each accepted input.
REQ-010 Port (MUX_2_TO_1_STATS_EN only): sel_b_count  output  16  saturating count of accepted selections of b.
REQ-011 Port: sel_a_count  output  16  saturating count of accepted selections of a (STATS_EN only).

Function
REQ-012 An input is accepted at a rising edge where rst=0 and in_valid=1.
REQ-013 On acceptance, y SHALL load (sel ? b : a) at that edge: one-cycle latency, no combinational path from inputs to y.
REQ-014 On acceptance, out_valid SHALL be 1 after that edge; otherwise out_valid SHALL be 0 after that edge.
REQ-015 With in_valid=0, y SHALL hold its last value; a, b and sel are don't-care.
REQ-016 Back-to-back acceptances SHALL produce one y update per cycle with no bubbles (full throughput).
REQ-017 Selection is bitwise over all WIDTH bits; no sign or width conversion.
REQ-018 No backpressure: the block always accepts; there is no ready signal.
REQ-019 Changes on a, b or sel between edges SHALL have no effect on y.

Reset
REQ-020 While rst=1 at a rising edge: y <= 0, out_valid <= 0, both counters <= 0; rst has priority over in_valid.
REQ-021 An input presented in the same cycle as rst=1 SHALL be discarded, not accepted.
REQ-022 Reset asserted mid-stream SHALL drop the pending output; the first valid after reset release is accepted normally.

Configuration
REQ-023 Macro MUX_2_TO_1_STATS_EN defined: sel_a_count and sel_b_count exist; each acceptance increments exactly the counter matching sel, saturating at 16'hFFFF (no wrap).
REQ-024 Macro MUX_2_TO_1_STATS_EN undefined: counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-025 Package mux_2_to_1_pkg SHALL hold: SEL_A=1'b0, SEL_B=1'b1, CNT_W=16, CNT_MAX, and the default WIDTH constant.
REQ-026 Counters SHALL be built from one sub-module, mux_2_to_1_sat_cnt (synchronous clear, enable, saturate at CNT_MAX), instantiated twice.
REQ-027 The datapath register and the out_valid flop live in mux_2_to_1 itself.

Verification
REQ-028 Reset: rst=1 for 2 cycles with in_valid=1, a=1, b=0 -> y=0, out_valid=0, counters 0.
REQ-029 Select: WIDTH=1; a=1, b=0, sel=0, in_valid=1 -> next cycle y=1, out_valid=1; then sel=1 -> y=0.
REQ-030 Hold: in_valid=0 for 5 cycles while a, b and sel toggle randomly -> y unchanged, out_valid=0.
REQ-031 Random: every 10 ns drive random a, b, sel with in_valid=1 for 1000 cycles -> y(t+1) = sel(t) ? b(t) : a(t) and out_valid=1 in every cycle.
REQ-032 Stats (STATS_EN): 70000 accepts with sel=1 -> sel_b_count=16'hFFFF, sel_a_count=0; then assert rst -> both counters 0.
REQ-033 Width: WIDTH=8; a=8'hA5, b=8'h3C, sel=1 -> y=8'h3C one cycle later.
